// File: rtl/nibble_serial_adder.sv
// Wide unsigned adder that reuses one 4-bit slice over NIBBLES cycles, LSB nibble first,
// with a registered carry between slices and valid/ready handshakes on both sides.
module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int NIBBLES = WIDTH / 4;
  localparam int IDXW    = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q;
  logic [WIDTH-1:0]  a_q;
  logic [WIDTH-1:0]  b_q;
  logic              carry_q;
  logic [IDXW-1:0]   idx_q;
  logic              inReady_q;
  logic              outValid_q;
  logic [WIDTH-1:0]  sum_q;
  logic              cout_q;

  logic [IDXW+1:0]   bitPos_d;
  logic [4:0]        slice_d;

  // The nibble currently being added sits at bit offset 4*idx.
  always_comb begin
    bitPos_d = {idx_q, 2'b00};
    slice_d  = {1'b0, a_q[bitPos_d +: 4]} + {1'b0, b_q[bitPos_d +: 4]} + {4'b0000, carry_q};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      a_q        <= '0;
      b_q        <= '0;
      carry_q    <= 1'b0;
      idx_q      <= '0;
      inReady_q  <= 1'b1;
      outValid_q <= 1'b0;
      sum_q      <= '0;
      cout_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && inReady_q) begin
            a_q       <= a;
            b_q       <= b;
            carry_q   <= cin;
            idx_q     <= '0;
            inReady_q <= 1'b0;
            state_q   <= ADD;
          end
        end
        ADD: begin
          sum_q[bitPos_d +: 4] <= slice_d[3:0];
          carry_q              <= slice_d[4];
          idx_q                <= idx_q + 1'b1;
          if (idx_q == LAST_IDX) begin
            cout_q     <= slice_d[4];
            outValid_q <= 1'b1;
            state_q    <= DONE;
          end
        end
        DONE: begin
          // Result stays frozen until the consumer takes it.
          if (out_ready) begin
            outValid_q <= 1'b0;
            inReady_q  <= 1'b1;
            state_q    <= IDLE;
          end
        end
        default: begin
          outValid_q <= 1'b0;
          inReady_q  <= 1'b1;
          state_q    <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = inReady_q;
  assign out_valid = outValid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed bench for nibble_serial_adder: a 16-bit instance driven from a vector table
// plus backpressure/reset sequences, and a 4-bit instance swept over every input.
module tb_nibble_serial_adder;

  typedef struct {
    string       name;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] expSum;
    logic        expCout;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        inValid16, inReady16, outValid16, outReady16, cin16, cout16;
  logic [15:0] a16, b16, sum16;

  logic        inValid4, inReady4, outValid4, outReady4, cin4, cout4;
  logic [3:0]  a4, b4, sum4;

  int vecCount  = 0;
  int missCount = 0;

  always #5 clk = ~clk;

  nibble_serial_adder #(.WIDTH(16)) dutWide (
    .clk(clk), .rst_n(rst_n),
    .in_valid(inValid16), .in_ready(inReady16),
    .a(a16), .b(b16), .cin(cin16),
    .out_valid(outValid16), .out_ready(outReady16),
    .sum(sum16), .cout(cout16)
  );

  nibble_serial_adder #(.WIDTH(4)) dutNarrow (
    .clk(clk), .rst_n(rst_n),
    .in_valid(inValid4), .in_ready(inReady4),
    .a(a4), .b(b4), .cin(cin4),
    .out_valid(outValid4), .out_ready(outReady4),
    .sum(sum4), .cout(cout4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vecCount++;
    if (actual !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // One full 16-bit transaction: offer, measure latency, then hand the result back.
  task automatic applyStimulus(input logic [15:0] opA, input logic [15:0] opB, input logic opCin,
                               output logic [15:0] resSum, output logic resCout);
    int  guard;
    int  lat;
    logic busyLow;
    guard = 0;
    while (!inReady16 && guard < 20) begin
      tick();
      guard++;
    end
    checkOutput("in_ready before offer", {31'd0, inReady16}, 32'd1);
    a16 = opA; b16 = opB; cin16 = opCin; inValid16 = 1'b1;
    tick();
    inValid16 = 1'b0;
    a16 = 16'($urandom); b16 = 16'($urandom); cin16 = 1'($urandom);
    lat = 0;
    busyLow = 1'b1;
    while (!outValid16 && lat < 20) begin
      if (inReady16) busyLow = 1'b0;
      tick();
      lat++;
    end
    if (inReady16) busyLow = 1'b0;
    checkOutput("wide latency", lat, 32'd4);
    checkOutput("wide in_ready low while busy", {31'd0, busyLow}, 32'd1);
    resSum  = sum16;
    resCout = cout16;
    outReady16 = 1'b1;
    tick();
    outReady16 = 1'b0;
    checkOutput("wide out_valid drops after handshake", {31'd0, outValid16}, 32'd0);
  endtask

  // One 4-bit transaction with a random consumer stall before the handshake.
  task automatic applyNarrow(input logic [3:0] opA, input logic [3:0] opB, input logic opCin);
    int lat;
    int stall;
    a4 = opA; b4 = opB; cin4 = opCin; inValid4 = 1'b1;
    checkOutput("narrow in_ready", {31'd0, inReady4}, 32'd1);
    tick();
    inValid4 = 1'b0;
    a4 = 4'($urandom); b4 = 4'($urandom); cin4 = 1'($urandom);
    lat = 0;
    while (!outValid4 && lat < 10) begin
      tick();
      lat++;
    end
    checkOutput("narrow latency", lat, 32'd1);
    stall = $urandom_range(0, 2);
    for (int s = 0; s < stall; s++) tick();
    checkOutput("narrow result", {27'd0, cout4, sum4}, {27'd0, 5'({1'b0, opA} + {1'b0, opB} + {4'd0, opCin})});
    outReady4 = 1'b1;
    tick();
    outReady4 = 1'b0;
  endtask

  initial begin
    vec_t        vecs[7];
    logic [15:0] gotSum;
    logic        gotCout;
    int          guard;
    logic        neverValid;

    vecs[0] = '{"basic 1234+4321",   16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0};
    vecs[1] = '{"ripple FFFF+0001",  16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
    vecs[2] = '{"max FFFF+FFFF+1",   16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
    vecs[3] = '{"alt AAAA+5555",     16'hAAAA, 16'h5555, 1'b0, 16'hFFFF, 1'b0};
    vecs[4] = '{"msb 8000+8000",     16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};
    vecs[5] = '{"mixed 0F0F+00F1+1", 16'h0F0F, 16'h00F1, 1'b1, 16'h1001, 1'b0};
    vecs[6] = '{"cin 7FFF+0000+1",   16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0};

    rst_n = 1'b0;
    inValid16 = 1'b0; outReady16 = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0;
    inValid4  = 1'b0; outReady4  = 1'b0; a4  = '0; b4  = '0; cin4  = 1'b0;
    tick(); tick(); tick();
    rst_n = 1'b1;
    checkOutput("reset in_ready",  {31'd0, inReady16},  32'd1);
    checkOutput("reset out_valid", {31'd0, outValid16}, 32'd0);
    checkOutput("reset sum",       {16'd0, sum16},      32'd0);
    checkOutput("reset cout",      {31'd0, cout16},     32'd0);

    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].cin, gotSum, gotCout);
      checkOutput({vecs[i].name, " sum"},  {16'd0, gotSum},  {16'd0, vecs[i].expSum});
      checkOutput({vecs[i].name, " cout"}, {31'd0, gotCout}, {31'd0, vecs[i].expCout});
    end

    // Backpressure: result must hold while stalled and a competing offer must be ignored.
    a16 = 16'h00F0; b16 = 16'h0010; cin16 = 1'b0; inValid16 = 1'b1;
    tick();
    inValid16 = 1'b0;
    guard = 0;
    while (!outValid16 && guard < 20) begin
      tick();
      guard++;
    end
    checkOutput("stall out_valid seen", {31'd0, outValid16}, 32'd1);
    a16 = 16'hAAAA; b16 = 16'h5555; inValid16 = 1'b1;
    for (int s = 0; s < 5; s++) begin
      tick();
      checkOutput("stall sum held",  {16'd0, sum16},      32'h0100);
      checkOutput("stall cout held", {31'd0, cout16},     32'd0);
      checkOutput("stall out_valid", {31'd0, outValid16}, 32'd1);
      checkOutput("stall in_ready",  {31'd0, inReady16},  32'd0);
    end
    inValid16 = 1'b0;
    outReady16 = 1'b1;
    tick();
    outReady16 = 1'b0;
    checkOutput("release in_ready",  {31'd0, inReady16},  32'd1);
    checkOutput("release out_valid", {31'd0, outValid16}, 32'd0);
    checkOutput("release sum kept",  {16'd0, sum16},      32'h0100);
    applyStimulus(16'hAAAA, 16'h5555, 1'b0, gotSum, gotCout);
    checkOutput("after stall sum",  {16'd0, gotSum},  32'hFFFF);
    checkOutput("after stall cout", {31'd0, gotCout}, 32'd0);

    // Reset during the second ADD cycle abandons the operation.
    a16 = 16'h8000; b16 = 16'h8000; cin16 = 1'b0; inValid16 = 1'b1;
    tick();
    inValid16 = 1'b0;
    neverValid = !outValid16;
    tick();
    if (outValid16) neverValid = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checkOutput("abort sum",       {16'd0, sum16},      32'd0);
    checkOutput("abort cout",      {31'd0, cout16},     32'd0);
    checkOutput("abort in_ready",  {31'd0, inReady16},  32'd1);
    for (int s = 0; s < 6; s++) begin
      if (outValid16) neverValid = 1'b0;
      tick();
    end
    checkOutput("abort no out_valid", {31'd0, neverValid}, 32'd1);
    applyStimulus(16'h0003, 16'h0004, 1'b0, gotSum, gotCout);
    checkOutput("post abort sum",  {16'd0, gotSum},  32'h0007);
    checkOutput("post abort cout", {31'd0, gotCout}, 32'd0);

    for (int x = 0; x < 16; x++)
      for (int y = 0; y < 16; y++)
        for (int c = 0; c < 2; c++)
          applyNarrow(4'(x), 4'(y), 1'(c));

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
